uart_cmd_responder: RTL and testbench

Byte-level command responder on the host side of the UART top level. It consumes received bytes (`rx_data`/`rx_ready`), parses fixed-length read/write command frames against a small internal register file, and returns one reply byte per frame through the transmit handshake (`tx_data`/`tx_send`/`tx_busy`). It is the far end of the UART link: remote initiator issues commands, this block answers.

---
 rtl/uart_cmd_pkg.sv | 19 +
 rtl/uart_cmd_responder_if.sv | 26 ++
 rtl/uart_cmd_regfile.sv | 39 +++
 rtl/uart_cmd_responder.sv | 133 +++++++++++++
 tb/tb_uart_cmd_responder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command responder.
package uart_cmd_pkg;

  localparam logic [7:0] OpWrite = 8'h57;
  localparam logic [7:0] OpRead  = 8'h52;
  localparam logic [7:0] Ack     = 8'h06;
  localparam logic [7:0] Nak     = 8'h15;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StExec,
    StSend,
    StWaitHi,
    StWaitLo
  } state_e;

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Byte-level receive strobe and transmit handshake between the UART core and the responder.
interface uart_cmd_responder_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;

  // UART core side: delivers received bytes, accepts reply bytes.
  modport master (
    output rx_data,
    output rx_ready,
    input  tx_data,
    input  tx_send,
    output tx_busy
  );

  // Responder side.
  modport slave (
    input  rx_data,
    input  rx_ready,
    output tx_data,
    output tx_send,
    input  tx_busy
  );
endinterface

// File: rtl/uart_cmd_regfile.sv
// Byte-wide register file: one write port, combinational read port, flattened view.
module uart_cmd_regfile #(
  parameter int unsigned num_regs = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [7:0]              addr,
  input  logic [7:0]              wdata,
  output logic [7:0]              rdata,
  output logic [8*num_regs-1:0]   reg_out
);

  logic [7:0] mem_q [num_regs];

  // Storage update; addresses beyond the file match no entry and are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < int'(num_regs); k++) mem_q[k] <= '0;
    end else if (we) begin
      for (int k = 0; k < int'(num_regs); k++) begin
        if (addr == 8'(k)) mem_q[k] <= wdata;
      end
    end
  end

  // Read mux; out-of-range addresses read as zero.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < int'(num_regs); k++) begin
      if (addr == 8'(k)) rdata = mem_q[k];
    end
  end

  for (genvar g = 0; g < int'(num_regs); g++) begin : g_flat
    assign reg_out[8*g +: 8] = mem_q[g];
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses read/write command frames from received bytes and answers each frame with one byte.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned num_regs       = 16,
  parameter int unsigned timeout_cycles = 20000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_cmd_responder_if.slave   bus,
  output logic [8*num_regs-1:0] reg_out,
  output logic                  frame_active,
  output logic                  cmd_error
);

  state_e      state_q;
  logic [7:0]  op_q, addr_q, data_q, tx_data_q;
  logic [31:0] tout_q;
  logic        cmd_error_q, frame_active_q;

  logic        addr_ok, we, nak, overrun, tout_last;
  logic [7:0]  rdata, reply;

  assign addr_ok   = 32'(addr_q) < num_regs;
  assign we        = (state_q == StExec) && (op_q == OpWrite) && addr_ok;
  assign tout_last = tout_q == timeout_cycles - 1;
  assign overrun   = bus.rx_ready && (state_q inside {StExec, StSend, StWaitHi, StWaitLo});

  uart_cmd_regfile #(
    .num_regs (num_regs)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .addr    (addr_q),
    .wdata   (data_q),
    .rdata   (rdata),
    .reg_out (reg_out)
  );

  // Reply selection for EXEC: anything not a valid in-range command is answered with NAK.
  always_comb begin
    nak   = 1'b1;
    reply = Nak;
    if (op_q == OpWrite && addr_ok) begin
      nak   = 1'b0;
      reply = Ack;
    end else if (op_q == OpRead && addr_ok) begin
      nak   = 1'b0;
      reply = rdata;
    end
  end

  // Frame parser and reply handshake; all outputs except tx_send are registered here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StIdle;
      op_q           <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      tx_data_q      <= '0;
      tout_q         <= '0;
      cmd_error_q    <= 1'b0;
      frame_active_q <= 1'b0;
    end else begin
      cmd_error_q <= overrun;
      unique case (state_q)
        StIdle: begin
          if (bus.rx_ready) begin
            op_q           <= bus.rx_data;
            tout_q         <= '0;
            frame_active_q <= 1'b1;
            // Unknown opcodes skip straight to EXEC so the NAK goes out without delay.
            state_q <= (bus.rx_data == OpWrite || bus.rx_data == OpRead) ? StGetAddr : StExec;
          end
        end
        StGetAddr: begin
          if (bus.rx_ready) begin
            addr_q  <= bus.rx_data;
            tout_q  <= '0;
            state_q <= (op_q == OpWrite) ? StGetData : StExec;
          end else if (tout_last) begin
            tout_q         <= '0;
            cmd_error_q    <= 1'b1;
            frame_active_q <= 1'b0;
            state_q        <= StIdle;
          end else begin
            tout_q <= tout_q + 32'd1;
          end
        end
        StGetData: begin
          if (bus.rx_ready) begin
            data_q  <= bus.rx_data;
            tout_q  <= '0;
            state_q <= StExec;
          end else if (tout_last) begin
            tout_q         <= '0;
            cmd_error_q    <= 1'b1;
            frame_active_q <= 1'b0;
            state_q        <= StIdle;
          end else begin
            tout_q <= tout_q + 32'd1;
          end
        end
        StExec: begin
          tx_data_q <= reply;
          if (nak) cmd_error_q <= 1'b1;
          state_q <= StSend;
        end
        StSend: begin
          if (!bus.tx_busy) state_q <= StWaitHi;
        end
        StWaitHi: begin
          if (bus.tx_busy) state_q <= StWaitLo;
        end
        StWaitLo: begin
          if (!bus.tx_busy) begin
            frame_active_q <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Request goes out in the first SEND cycle the transmitter is free; leaving SEND ends it.
  assign bus.tx_send = (state_q == StSend) && !bus.tx_busy;
  assign bus.tx_data = tx_data_q;
  assign cmd_error   = cmd_error_q;
  assign frame_active = frame_active_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Randomised scoreboard bench for the UART command responder.
module tb_uart_cmd_responder;

  localparam int unsigned NumRegs = 16;
  localparam int unsigned Tout    = 200;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_responder_if bus ();
  logic [8*NumRegs-1:0] reg_out;
  logic frame_active, cmd_error;
  logic busy_model = 1'b0;
  logic force_busy = 1'b0;
  int   busy_len = 3;

  assign bus.tx_busy = busy_model | force_busy;

  uart_cmd_responder #(
    .num_regs       (NumRegs),
    .timeout_cycles (Tout)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .reg_out      (reg_out),
    .frame_active (frame_active),
    .cmd_error    (cmd_error)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0;
  logic [7:0] model_regs [NumRegs];
  logic [7:0] exp_q [$];
  int err_exp = 0, err_seen = 0, sends = 0;
  int last_send_cyc = -1, last_byte_cyc = -1;
  logic prev_send = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor/scoreboard: pops expected reply on every tx_send, counts error pulses.
  always @(negedge clk) begin
    if (cmd_error) err_seen++;
    if (bus.tx_send) begin
      sends++;
      last_send_cyc = cyc;
      check("tx_send gap", int'(prev_send), 0);
      check("reply pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("reply byte", int'(bus.tx_data), int'(exp_q.pop_front()));
    end
    prev_send = bus.tx_send;
  end

  // Transmitter model: busy rises the cycle after a request and holds busy_len cycles.
  always begin
    @(negedge clk);
    if (bus.tx_send) begin
      @(posedge clk);
      #1 busy_model = 1'b1;
      repeat (busy_len) @(posedge clk);
      #1 busy_model = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    last_byte_cyc = cyc;
    @(posedge clk);
    #1 bus.rx_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Reference model: one frame's effect on the registers and the byte it must answer with.
  task automatic run_frame(input logic [7:0] op, input logic [7:0] addr,
                           input logic [7:0] data, input int gap);
    logic [7:0] r;
    send_byte(op);
    if (op == 8'h57 || op == 8'h52) begin
      idle(gap);
      send_byte(addr);
      if (op == 8'h57) begin
        idle(gap);
        send_byte(data);
      end
    end
    if (op == 8'h57 && addr < NumRegs) begin
      model_regs[addr] = data;
      r = 8'h06;
    end else if (op == 8'h52 && addr < NumRegs) begin
      r = model_regs[addr];
    end else begin
      r = 8'h15;
      err_exp++;
    end
    exp_q.push_back(r);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while ((sends < target || frame_active) && t < 400) begin
      @(posedge clk);
      t++;
    end
    check("replies seen", sends, target);
    check("frame closed", int'(frame_active), 0);
  endtask

  task automatic check_regs();
    for (int k = 0; k < int'(NumRegs); k++)
      check($sformatf("reg%0d", k), int'(reg_out[8*k +: 8]), int'(model_regs[k]));
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, " reg_out"}, int'(reg_out != '0), 0);
    check({tag, " tx_data"}, int'(bus.tx_data), 0);
    check({tag, " tx_send"}, int'(bus.tx_send), 0);
    check({tag, " frame_active"}, int'(frame_active), 0);
    check({tag, " cmd_error"}, int'(cmd_error), 0);
  endtask

  initial begin
    int s0, rel, t;
    logic [7:0] op;
    bus.rx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    for (int k = 0; k < int'(NumRegs); k++) model_regs[k] = 8'h00;

    idle(3);
    check_reset_outputs("reset");
    #1 reset = 1'b1;

    // Write, then confirm ACK lands two cycles after the last byte's cycle.
    run_frame(8'h57, 8'h03, 8'hA5, 0);
    wait_done(1);
    check("ack latency", last_send_cyc - last_byte_cyc, 2);
    check_regs();

    run_frame(8'h52, 8'h03, 8'h00, 1);
    wait_done(2);

    // Unknown opcode and out-of-range write both NAK.
    run_frame(8'h41, 8'h00, 8'h00, 0);
    wait_done(3);
    run_frame(8'h57, 8'h10, 8'hFF, 2);
    wait_done(4);
    check_regs();
    check("nak errors", err_seen, err_exp);

    // Incomplete frame times out silently, except for the error pulse.
    send_byte(8'h57);
    send_byte(8'h02);
    idle(Tout + 5);
    err_exp++;
    check("timeout no reply", sends, 4);
    check("timeout error", err_seen, err_exp);
    check("timeout idle", int'(frame_active), 0);
    run_frame(8'h52, 8'h02, 8'h00, 0);
    wait_done(5);

    // Transmitter held busy across EXEC: request must wait for it.
    force_busy = 1'b1;
    run_frame(8'h57, 8'h05, 8'h3C, 0);
    s0 = sends;
    idle(50);
    check("deferred send", sends, s0);
    #1;
    rel = cyc;
    force_busy = 1'b0;
    wait_done(s0 + 1);
    check("send after busy", int'(last_send_cyc >= rel), 1);

    // Byte arriving while the reply is still on the wire is dropped as an overrun.
    busy_len = 8;
    run_frame(8'h52, 8'h05, 8'h00, 0);
    t = 0;
    while (sends < s0 + 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    idle(2);
    send_byte(8'hAA);
    err_exp++;
    wait_done(s0 + 2);
    check("overrun error", err_seen, err_exp);
    check_regs();

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      int sel;
      busy_len = int'($urandom_range(1, 4));
      sel = int'($urandom_range(0, 99));
      if (sel < 45) op = 8'h57;
      else if (sel < 85) op = 8'h52;
      else begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
      end
      run_frame(op, 8'($urandom_range(0, 19)), 8'($urandom), int'($urandom_range(0, 5)));
      wait_done(sends + exp_q.size());
    end
    check_regs();
    check("random errors", err_seen, err_exp);

    // Reset while waiting for the data byte.
    s0 = sends;
    send_byte(8'h57);
    send_byte(8'h07);
    reset = 1'b0;
    @(posedge clk);
    check_reset_outputs("reset in data");
    for (int k = 0; k < int'(NumRegs); k++) model_regs[k] = 8'h00;
    #1 reset = 1'b1;
    idle(20);
    check("no send after reset", sends, s0);

    // Reset while waiting for busy to rise after the request.
    run_frame(8'h57, 8'h01, 8'h77, 0);
    wait_done(s0 + 1);
    busy_len = 6;
    run_frame(8'h52, 8'h01, 8'h00, 0);
    t = 0;
    while (sends < s0 + 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1 reset = 1'b0;
    @(posedge clk);
    check_reset_outputs("reset in wait_hi");
    for (int k = 0; k < int'(NumRegs); k++) model_regs[k] = 8'h00;
    #1 reset = 1'b1;
    idle(20);
    check("no send after reset2", sends, s0 + 2);
    run_frame(8'h52, 8'h01, 8'h00, 0);
    wait_done(s0 + 3);
    check_regs();

    check("queue drained", exp_q.size(), 0);
    check("final errors", err_seen, err_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
